tod_switch_ctrl: RTL and testbench
==================================

Name: tod_switch_ctrl

Overview:
- Sequences glitch-free switchover of the E-tile PTP Time-of-Day source between the 10G and 25G ToD generators during a runtime rate change.
- Drives the source-select, and registers and freezes the selected TX/RX ToD while the switch is in progress.
- Qualifies the output with a valid flag, so downstream timestamping never sees a torn or unsettled ToD.
- Sits between the two ToD generators and the E-tile MAC ToD inputs; a software CSR bridge issues switch requests.

Parameters:
- TOD_W, 96: ToD width (48b s, 32b ns, 16b fractional ns).
- SETTLE_CYC, 16: cycles to hold after the select changes, before checking the new source; must be >= 1.
- TIMEOUT_CYC, 1024: maximum cycles to wait for the new source's valid; must be >= 1.
- RESET_SEL, 0: select value after reset (0 = 10G, 1 = 25G).

Ports:
- clk, in, 1: ToD/PTP clock; all logic is on this clock.
- reset, in, 1: synchronous, active-high reset.
- sw_req, in, 1: single-cycle switch request.
- sw_target, in, 1: requested source (0 = 10G, 1 = 25G); sampled together with sw_req.
- sw_busy, out, 1: high while a switch is in progress.
- sw_done, out, 1: one-cycle pulse when a switch succeeds or is a no-op.
- sw_err, out, 1: one-cycle pulse when a switch times out.
- sel, out, 1: current source select.
- tod10g_valid, in, 1: 10G ToD generator locked/valid.
- tod25g_valid, in, 1: 25G ToD generator locked/valid.
- tx_tod10g, rx_tod10g, in, TOD_W: 10G ToD.
- tx_tod25g, rx_tod25g, in, TOD_W: 25G ToD.
- tx_tod_out, rx_tod_out, out, TOD_W: registered, muxed ToD to the MAC.
- tod_out_valid, out, 1: tx_tod_out/rx_tod_out are trustworthy.

Behaviour:
- Reset values:
  - state = IDLE, sel = RESET_SEL.
  - tx_tod_out = rx_tod_out = 0.
  - tod_out_valid = 0; sw_busy, sw_done, sw_err = 0.
  - Counters = 0.
- Reset mid-switch aborts the switch immediately to these values; no done or err pulse.
- Datapath, IDLE only, every clk edge:
  - tx_tod_out/rx_tod_out take the source chosen by sel.
  - tod_out_valid takes that source's valid.
  - Latency is 1 cycle.
- Datapath, all other states: ToD outputs hold their last value; tod_out_valid = 0.
- State machine (transitions happen on the clk edge):
  - IDLE:
    - sw_req=1 and sw_target==sel: stay IDLE; sw_done=1 next cycle (no-op).
    - sw_req=1 and sw_target!=sel: latch target and prev_sel, go to QUIESCE; sw_busy=1 from the next cycle.
  - QUIESCE (1 cycle): go to SETTLE; sel = latched target; settle counter = 0.
  - SETTLE: counter increments each cycle; after SETTLE_CYC cycles in SETTLE, go to WAIT_VALID with timeout counter = 0.
  - WAIT_VALID:
    - If the new source's valid is 1: go to IDLE, sw_done=1 for 1 cycle, sw_busy=0.
    - Otherwise, when the timeout counter reaches TIMEOUT_CYC-1: set sel = prev_sel, go to IDLE, sw_err=1 for 1 cycle, sw_busy=0.
- sw_req while sw_busy=1 is ignored and not queued.
- sw_req in the same cycle that the state returns to IDLE is also ignored.
- sw_done and sw_err are never asserted together.
- A valid that deasserts during SETTLE is not checked; only WAIT_VALID samples valid.
- Counters are $clog2-sized and saturate, never wrapping.
- Success latency, with the new source valid throughout:
  - Request sampled at edge 0 → QUIESCE.
  - Edge 1 → SETTLE, sel changes.
  - Edge SETTLE_CYC+1 → WAIT_VALID.
  - Edge SETTLE_CYC+2 → IDLE, sw_done.
  - Edge SETTLE_CYC+3 → tod_out_valid=1 with new-source ToD.
- The old source's valid dropping while IDLE propagates to tod_out_valid with 1-cycle latency; sel is not changed.

Test Plan:
- Reset → sel=0, tod_out_valid=0, tod outputs 0. Then tod10g_valid=1, tx_tod10g=0x1234 → next cycle tx_tod_out=0x1234, tod_out_valid=1.
- Switch 10G→25G, defaults, tod25g_valid=1:
  - sw_req with target=1 at edge 0 → sel=1 after edge 1.
  - Outputs frozen and valid=0 for cycles 1–18.
  - sw_done pulse after edge 18.
  - tod_out_valid=1 with tx_tod25g after edge 19.
- No-op request: sw_req with target=0 while sel=0 → sw_done=1 for exactly one cycle; sel, valid and ToD outputs are uninterrupted.
- Timeout, TIMEOUT_CYC=8, tod25g_valid=0:
  - Switch to 25G → 8 cycles in WAIT_VALID, then sel returns to 0 and sw_err pulses once; no sw_done.
  - tod_out_valid resumes from 10G one cycle later.
- Busy guard: second sw_req with target=0 issued at cycle 5 of SETTLE → ignored; the switch completes to sel=1 with a single sw_done.
- Reset asserted at cycle 3 of SETTLE → next cycle sel=RESET_SEL, sw_busy=0, no pulses, state IDLE; a following switch works normally.

Source files
------------

// File: rtl/tod_switch_ctrl_if.sv
// ---------------------------------------------------------------------------
// tod_switch_ctrl_if
//
// Purpose:
//   Bundles the ToD switchover signals into one interface. These are the
//   CSR-side switch handshake, the two ToD generator feeds and the muxed
//   ToD toward the E-tile MAC. Clock and reset are not part of it.
//
// Modports:
//   master - environment side. It drives the switch request and the
//            generator ToD/valid inputs, and observes the controller outputs.
//   slave  - controller side (tod_switch_ctrl).
//
// Signals:
//   sw_req, sw_target         : single-cycle switch request and its target
//                               (0 = 10G, 1 = 25G)
//   sw_busy, sw_done, sw_err  : switch status (busy level, done/err pulses)
//   sel                       : current ToD source select
//   tod10g_valid/tod25g_valid : generator locked/valid flags
//   tx/rx_tod10g, tx/rx_tod25g: generator ToD values (TOD_W bits)
//   tx/rx_tod_out             : registered, muxed ToD toward the MAC
//   tod_out_valid             : the ToD outputs are trustworthy
// ---------------------------------------------------------------------------
interface tod_switch_ctrl_if #(
    parameter int TOD_W = 96
);
    logic             sw_req;
    logic             sw_target;
    logic             sw_busy;
    logic             sw_done;
    logic             sw_err;
    logic             sel;
    logic             tod10g_valid;
    logic             tod25g_valid;
    logic [TOD_W-1:0] tx_tod10g;
    logic [TOD_W-1:0] rx_tod10g;
    logic [TOD_W-1:0] tx_tod25g;
    logic [TOD_W-1:0] rx_tod25g;
    logic [TOD_W-1:0] tx_tod_out;
    logic [TOD_W-1:0] rx_tod_out;
    logic             tod_out_valid;

    modport master (
        output sw_req,
        output sw_target,
        input  sw_busy,
        input  sw_done,
        input  sw_err,
        input  sel,
        output tod10g_valid,
        output tod25g_valid,
        output tx_tod10g,
        output rx_tod10g,
        output tx_tod25g,
        output rx_tod25g,
        input  tx_tod_out,
        input  rx_tod_out,
        input  tod_out_valid
    );

    modport slave (
        input  sw_req,
        input  sw_target,
        output sw_busy,
        output sw_done,
        output sw_err,
        output sel,
        input  tod10g_valid,
        input  tod25g_valid,
        input  tx_tod10g,
        input  rx_tod10g,
        input  tx_tod25g,
        input  rx_tod25g,
        output tx_tod_out,
        output rx_tod_out,
        output tod_out_valid
    );
endinterface

// File: rtl/tod_switch_ctrl.sv
// ---------------------------------------------------------------------------
// tod_switch_ctrl
//
// Purpose:
//   Switches the E-tile PTP Time-of-Day source between the 10G and 25G ToD
//   generators without glitches during a runtime rate change. While IDLE,
//   the selected generator's TX/RX ToD and its valid flag are registered
//   toward the MAC with one cycle of latency. During a switch the ToD
//   outputs are frozen and tod_out_valid is held low. This way downstream
//   timestamping never sees a torn value or a value from an unsettled
//   generator.
//
//   Switch sequence:
//     IDLE -> QUIESCE (1 cycle) -> SETTLE (SETTLE_CYC cycles, sel already
//     moved) -> WAIT_VALID (until the new source is valid, or TIMEOUT_CYC
//     cycles) -> IDLE.
//   On timeout the select reverts to the previous source and sw_err pulses.
//   On success, or for a request that targets the current source, sw_done
//   pulses.
//
// Ports:
//   clk   : ToD/PTP clock; every register is on this clock
//   reset : synchronous, active-high reset
//   bus   : tod_switch_ctrl_if.slave (switch handshake, generator inputs,
//           muxed ToD outputs)
//
// Parameters:
//   TOD_W       : ToD width (48b s, 32b ns, 16b fractional ns)
//   SETTLE_CYC  : hold cycles after the select changes (>= 1)
//   TIMEOUT_CYC : maximum cycles to wait for the new source valid (>= 1)
//   RESET_SEL   : select value after reset (0 = 10G, 1 = 25G)
// ---------------------------------------------------------------------------
module tod_switch_ctrl #(
    parameter int   TOD_W       = 96,
    parameter int   SETTLE_CYC  = 16,
    parameter int   TIMEOUT_CYC = 1024,
    parameter logic RESET_SEL   = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    tod_switch_ctrl_if.slave     bus
);

    // Out-of-range parameters are clamped to 1 so the counters stay
    // well formed.
    localparam int SETTLE_EFF  = (SETTLE_CYC  < 1) ? 1 : SETTLE_CYC;
    localparam int TIMEOUT_EFF = (TIMEOUT_CYC < 1) ? 1 : TIMEOUT_CYC;

    // The +1 keeps the counters at least one bit wide, even for a count of 1.
    localparam int SCNT_W = $clog2(SETTLE_EFF + 1);
    localparam int TCNT_W = $clog2(TIMEOUT_EFF + 1);

    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SETTLE_EFF - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_EFF - 1);
    localparam logic [SCNT_W-1:0] SCNT_MAX  = {SCNT_W{1'b1}};
    localparam logic [TCNT_W-1:0] TCNT_MAX  = {TCNT_W{1'b1}};

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_QUIESCE    = 2'd1;
    localparam logic [1:0] ST_SETTLE     = 2'd2;
    localparam logic [1:0] ST_WAIT_VALID = 2'd3;

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    logic [1:0]        r_state;
    logic              r_sel;
    logic              r_target;
    logic              r_prev_sel;
    logic [SCNT_W-1:0] r_settle_cnt;
    logic [TCNT_W-1:0] r_tmo_cnt;
    logic              r_done;
    logic              r_err;

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    logic [TOD_W-1:0]  r_tx_tod_out;
    logic [TOD_W-1:0]  r_rx_tod_out;
    logic              r_tod_out_valid;

    // -----------------------------------------------------------------------
    // Next-state wires
    // -----------------------------------------------------------------------
    logic [1:0]        w_state_next;
    logic              w_sel_next;
    logic              w_target_next;
    logic              w_prev_sel_next;
    logic [SCNT_W-1:0] w_settle_cnt_next;
    logic [TCNT_W-1:0] w_tmo_cnt_next;
    logic              w_done_next;
    logic              w_err_next;

    // Source currently chosen by sel. In WAIT_VALID, sel already equals the
    // latched target, so w_src_valid is also the new source's valid.
    logic [TOD_W-1:0]  w_src_tx;
    logic [TOD_W-1:0]  w_src_rx;
    logic              w_src_valid;

    assign w_src_valid = r_sel ? bus.tod25g_valid : bus.tod10g_valid;

    genvar gi;
    generate
        for (gi = 0; gi < TOD_W; gi++) begin : g_tod_mux
            assign w_src_tx[gi] = r_sel ? bus.tx_tod25g[gi] : bus.tx_tod10g[gi];
            assign w_src_rx[gi] = r_sel ? bus.rx_tod25g[gi] : bus.rx_tod10g[gi];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Switch sequencer (next-state logic)
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_sel_next        = r_sel;
        w_target_next     = r_target;
        w_prev_sel_next   = r_prev_sel;
        w_settle_cnt_next = r_settle_cnt;
        w_tmo_cnt_next    = r_tmo_cnt;
        w_done_next       = 1'b0;
        w_err_next        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Requests are only accepted here. A request that arrives
                // while busy, or in the cycle that returns to IDLE, is
                // therefore dropped.
                if (bus.sw_req) begin
                    if (bus.sw_target == r_sel) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_target_next   = bus.sw_target;
                        w_prev_sel_next = r_sel;
                        w_state_next    = ST_QUIESCE;
                    end
                end
            end

            ST_QUIESCE: begin
                // The ToD outputs are already frozen at this point, so moving
                // sel here cannot tear a value seen by the MAC.
                w_sel_next        = r_target;
                w_settle_cnt_next = '0;
                w_state_next      = ST_SETTLE;
            end

            ST_SETTLE: begin
                // Valid is deliberately ignored while settling.
                if (r_settle_cnt >= SCNT_LAST) begin
                    w_tmo_cnt_next = '0;
                    w_state_next   = ST_WAIT_VALID;
                end else if (r_settle_cnt != SCNT_MAX) begin
                    w_settle_cnt_next = r_settle_cnt + SCNT_W'(1);
                end
            end

            ST_WAIT_VALID: begin
                if (w_src_valid) begin
                    w_done_next  = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (r_tmo_cnt >= TCNT_LAST) begin
                    // Fall back to the source that was running before.
                    w_sel_next   = r_prev_sel;
                    w_err_next   = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (r_tmo_cnt != TCNT_MAX) begin
                    w_tmo_cnt_next = r_tmo_cnt + TCNT_W'(1);
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Sequencer registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_sel        <= RESET_SEL;
            r_target     <= RESET_SEL;
            r_prev_sel   <= RESET_SEL;
            r_settle_cnt <= '0;
            r_tmo_cnt    <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_sel        <= w_sel_next;
            r_target     <= w_target_next;
            r_prev_sel   <= w_prev_sel_next;
            r_settle_cnt <= w_settle_cnt_next;
            r_tmo_cnt    <= w_tmo_cnt_next;
            r_done       <= w_done_next;
            r_err        <= w_err_next;
        end
    end

    // -----------------------------------------------------------------------
    // ToD datapath: tracks the selected source only while IDLE. In every
    // other state it holds the last ToD and reports it as not valid.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_tod_out    <= '0;
            r_rx_tod_out    <= '0;
            r_tod_out_valid <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_tx_tod_out    <= w_src_tx;
            r_rx_tod_out    <= w_src_rx;
            r_tod_out_valid <= w_src_valid;
        end else begin
            r_tod_out_valid <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.sw_busy       = (r_state != ST_IDLE);
    assign bus.sw_done       = r_done;
    assign bus.sw_err        = r_err;
    assign bus.sel           = r_sel;
    assign bus.tx_tod_out    = r_tx_tod_out;
    assign bus.rx_tod_out    = r_rx_tod_out;
    assign bus.tod_out_valid = r_tod_out_valid;

endmodule

// File: tb/tb_tod_switch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tod_switch_ctrl
//
// Self-checking bench for tod_switch_ctrl. Level expectations (sel, valid,
// ToD, busy) are queued with the cycle at which they must hold. Done and
// err pulses are queued in order. A negedge monitor pops the queued
// entries and compares them with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_tod_switch_ctrl;
    localparam int TOD_W = 96;
    localparam int S     = 16;
    localparam int T     = 8;

    localparam int F_SEL   = 0;
    localparam int F_VALID = 1;
    localparam int F_TX    = 2;
    localparam int F_RX    = 3;
    localparam int F_BUSY  = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tod_switch_ctrl_if #(.TOD_W(TOD_W)) bus_if ();

    tod_switch_ctrl #(
        .TOD_W       (TOD_W),
        .SETTLE_CYC  (S),
        .TIMEOUT_CYC (T),
        .RESET_SEL   (1'b0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    typedef struct {
        int           at;
        int           fld;
        logic [127:0] val;
        string        tag;
    } exp_t;

    typedef struct {
        int at;
        bit is_err;
    } pulse_t;

    exp_t   exp_q[$];
    pulse_t pulse_q[$];
    int     n_vec = 0;
    int     n_mis = 0;
    int     cyc   = 0;
    bit     model_sel = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input logic [127:0] obs, input logic [127:0] req);
        n_vec++;
        if (obs !== req) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (cyc %0d)", tag, obs, req, cyc);
        end
    endtask

    function automatic logic [127:0] observe(input int f);
        case (f)
            F_SEL:   return 128'(bus_if.sel);
            F_VALID: return 128'(bus_if.tod_out_valid);
            F_TX:    return 128'(bus_if.tx_tod_out);
            F_RX:    return 128'(bus_if.rx_tod_out);
            default: return 128'(bus_if.sw_busy);
        endcase
    endfunction

    function automatic logic [TOD_W-1:0] src_tx(input bit s);
        return s ? bus_if.tx_tod25g : bus_if.tx_tod10g;
    endfunction

    function automatic logic [TOD_W-1:0] src_rx(input bit s);
        return s ? bus_if.rx_tod25g : bus_if.rx_tod10g;
    endfunction

    task automatic expect_at(input int at, input int f, input logic [127:0] v, input string tag);
        exp_q.push_back('{at, f, v, tag});
    endtask

    task automatic expect_pulse(input int at, input bit is_err);
        pulse_q.push_back('{at, is_err});
    endtask

    task automatic wait_until(input int at);
        while (cyc < at) @(negedge clk);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin : mon
        int     i;
        pulse_t p;
        i = 0;
        while (i < exp_q.size()) begin
            if (exp_q[i].at == cyc) begin
                chk_eq(exp_q[i].tag, observe(exp_q[i].fld), exp_q[i].val);
                exp_q.delete(i);
            end else begin
                i++;
            end
        end
        if (bus_if.sw_done || bus_if.sw_err) begin
            chk_eq("done_err_exclusive", 128'(bus_if.sw_done & bus_if.sw_err), 128'(0));
            if (pulse_q.size() == 0) begin
                chk_eq("unexpected_pulse", 128'({bus_if.sw_err, bus_if.sw_done}), 128'(0));
            end else begin
                p = pulse_q.pop_front();
                chk_eq("pulse_cycle", 128'(cyc), 128'(p.at));
                chk_eq("pulse_is_err", 128'(bus_if.sw_err), 128'(p.is_err));
            end
        end
    end

    task automatic run_noop(input bit tgt);
        int e0;
        @(negedge clk);
        e0 = cyc + 1;
        bus_if.sw_req    = 1'b1;
        bus_if.sw_target = tgt;
        expect_pulse(e0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            expect_at(e0 + k, F_SEL,   128'(model_sel), "noop_sel");
            expect_at(e0 + k, F_VALID, 128'(1),         "noop_valid");
            expect_at(e0 + k, F_TX,    128'(src_tx(model_sel)), "noop_tx");
        end
        expect_at(e0, F_BUSY, 128'(0), "noop_busy");
        @(negedge clk);
        bus_if.sw_req = 1'b0;
        wait_until(e0 + 3);
        chk_eq("noop_pulse_pending", 128'(pulse_q.size()), 128'(0));
    endtask

    // ok: new source expected to come valid; guard_at > 0 injects an opposite
    // request while busy; rst_at > 0 asserts reset so it is sampled at edge
    // e0+rst_at.
    task automatic run_switch(input bit tgt, input bit ok, input int guard_at, input int rst_at);
        int               e0, te, last;
        bit               old;
        logic [TOD_W-1:0] old_tx, old_rx, new_tx, new_rx;
        old = model_sel;
        @(negedge clk);
        e0 = cyc + 1;
        bus_if.sw_req    = 1'b1;
        bus_if.sw_target = tgt;
        old_tx = src_tx(old);
        old_rx = src_rx(old);
        new_tx = src_tx(tgt);
        new_rx = src_rx(tgt);
        expect_at(e0,     F_SEL,   128'(old),    "sw_sel_edge0");
        expect_at(e0,     F_BUSY,  128'(1),      "sw_busy_edge0");
        expect_at(e0,     F_VALID, 128'(1),      "sw_valid_edge0");
        expect_at(e0,     F_TX,    128'(old_tx), "sw_tx_edge0");
        expect_at(e0 + 1, F_SEL,   128'(tgt),    "sw_sel_edge1");
        expect_at(e0 + 1, F_VALID, 128'(0),      "sw_valid_edge1");
        @(negedge clk);
        bus_if.sw_req = 1'b0;
        // Move the old source on so a frozen output is distinguishable.
        if (old) bus_if.tx_tod25g = old_tx + 96'd7;
        else     bus_if.tx_tod10g = old_tx + 96'd7;

        if (rst_at > 0) begin
            wait_until(e0 + rst_at - 1);
            reset = 1'b1;
            expect_at(e0 + rst_at, F_SEL,   128'(0), "rst_mid_sel");
            expect_at(e0 + rst_at, F_BUSY,  128'(0), "rst_mid_busy");
            expect_at(e0 + rst_at, F_VALID, 128'(0), "rst_mid_valid");
            expect_at(e0 + rst_at, F_TX,    128'(0), "rst_mid_tx");
            @(negedge clk);
            reset = 1'b0;
            expect_at(e0 + rst_at + 1, F_VALID, 128'(1),         "rst_after_valid");
            expect_at(e0 + rst_at + 1, F_TX,    128'(src_tx(0)), "rst_after_tx");
            model_sel = 1'b0;
            last = e0 + rst_at + 1;
        end else if (ok) begin
            expect_at(e0 + S + 1, F_VALID, 128'(0),      "sw_frozen_valid");
            expect_at(e0 + S + 1, F_TX,    128'(old_tx), "sw_frozen_tx");
            expect_at(e0 + S + 1, F_RX,    128'(old_rx), "sw_frozen_rx");
            expect_at(e0 + S + 1, F_BUSY,  128'(1),      "sw_busy_wait");
            expect_at(e0 + S + 2, F_BUSY,  128'(0),      "sw_busy_done");
            expect_at(e0 + S + 2, F_VALID, 128'(0),      "sw_valid_done");
            expect_pulse(e0 + S + 2, 1'b0);
            expect_at(e0 + S + 3, F_VALID, 128'(1),      "sw_valid_new");
            expect_at(e0 + S + 3, F_TX,    128'(new_tx), "sw_tx_new");
            expect_at(e0 + S + 3, F_RX,    128'(new_rx), "sw_rx_new");
            expect_at(e0 + S + 3, F_SEL,   128'(tgt),    "sw_sel_new");
            if (guard_at > 0) begin
                wait_until(e0 + guard_at);
                bus_if.sw_req    = 1'b1;
                bus_if.sw_target = old;
                expect_at(e0 + guard_at + 2, F_SEL, 128'(tgt), "guard_sel");
                @(negedge clk);
                bus_if.sw_req = 1'b0;
            end
            model_sel = tgt;
            last = e0 + S + 3;
        end else begin
            te = e0 + S + 1 + T;
            expect_at(te - 1, F_SEL,   128'(tgt),    "tmo_sel_before");
            expect_at(te - 1, F_BUSY,  128'(1),      "tmo_busy_before");
            expect_at(te,     F_SEL,   128'(old),    "tmo_sel_revert");
            expect_at(te,     F_BUSY,  128'(0),      "tmo_busy_end");
            expect_at(te,     F_VALID, 128'(0),      "tmo_valid_end");
            expect_at(te,     F_TX,    128'(old_tx), "tmo_frozen_tx");
            expect_pulse(te, 1'b1);
            expect_at(te + 1, F_VALID, 128'(1),           "tmo_valid_resume");
            expect_at(te + 1, F_TX,    128'(src_tx(old)), "tmo_tx_resume");
            last = te + 1;
        end
        wait_until(last + 2);
        chk_eq("sw_pulse_pending", 128'(pulse_q.size()), 128'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, cyc %0d", cyc);
        $fatal(1);
    end

    initial begin
        bus_if.sw_req       = 1'b0;
        bus_if.sw_target    = 1'b0;
        bus_if.tod10g_valid = 1'b0;
        bus_if.tod25g_valid = 1'b0;
        bus_if.tx_tod10g    = '0;
        bus_if.rx_tod10g    = '0;
        bus_if.tx_tod25g    = '0;
        bus_if.rx_tod25g    = '0;
        reset = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        expect_at(cyc + 1, F_SEL,   128'(0), "rst_sel");
        expect_at(cyc + 1, F_VALID, 128'(0), "rst_valid");
        expect_at(cyc + 1, F_TX,    128'(0), "rst_tx");
        expect_at(cyc + 1, F_RX,    128'(0), "rst_rx");
        expect_at(cyc + 1, F_BUSY,  128'(0), "rst_busy");

        // First capture from the 10G generator
        @(negedge clk);
        reset               = 1'b0;
        bus_if.tod10g_valid = 1'b1;
        bus_if.tx_tod10g    = 96'h1234;
        bus_if.rx_tod10g    = 96'h5678;
        bus_if.tod25g_valid = 1'b1;
        bus_if.tx_tod25g    = 96'hA5A5_0000_0000_0001;
        bus_if.rx_tod25g    = 96'h5A5A_0000_0000_0002;
        expect_at(cyc + 1, F_TX,    128'h1234, "dp_tx10");
        expect_at(cyc + 1, F_RX,    128'h5678, "dp_rx10");
        expect_at(cyc + 1, F_VALID, 128'(1),   "dp_valid10");

        // A drop of the 10G valid while IDLE reaches tod_out_valid after 1 cycle
        @(negedge clk);
        bus_if.tod10g_valid = 1'b0;
        expect_at(cyc + 1, F_VALID, 128'(0), "dp_valid_drop");
        expect_at(cyc + 1, F_SEL,   128'(0), "dp_sel_kept");
        @(negedge clk);
        bus_if.tod10g_valid = 1'b1;
        expect_at(cyc + 1, F_VALID, 128'(1), "dp_valid_back");
        @(negedge clk);

        run_noop(1'b0);                         // no-op to the current source
        run_switch(1'b1, 1'b1, 0, 0);           // 10G -> 25G
        run_switch(1'b0, 1'b1, 0, 0);           // 25G -> 10G
        run_switch(1'b1, 1'b1, 0, 4);           // reset during SETTLE
        bus_if.tod25g_valid = 1'b0;
        run_switch(1'b1, 1'b0, 0, 0);           // timeout, revert to 10G
        bus_if.tod25g_valid = 1'b1;
        run_switch(1'b1, 1'b1, 5, 0);           // busy guard: extra request ignored

        chk_eq("exp_left",    128'(exp_q.size()),   128'(0));
        chk_eq("pulses_left", 128'(pulse_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
